mac_datapath: RTL
=================

# mac_datapath

- Execution datapath for the dot-product controller.
- Acts on the controller's command strobes:
  - latches operand words
  - multiply-accumulates them in signed fixed point
  - saturates and stores one result per output neuron in a Q-deep buffer
- After the controller signals `done`, it drains the buffer to a downstream consumer over a valid/ready handshake.

## Interface
- `N`, 8: operand and result width, signed two's complement.
- `D`, 4: products per dot product; sizes accumulator guard bits.
- `Q`, 4: result buffer depth (output neurons per frame); need not be a power of two.
- `FRAC`, 4: fractional bits of the operand format.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `write_x` input 1: latch `x_in` into the X operand register.
- `write_w` input 1: latch `w_in` into the W operand register.
- `x_in` input N: data operand.
- `w_in` input N: weight operand.
- `acc_write` input 1: accumulate X*W.
- `res_write` input 1: store the scaled, saturated accumulator into the buffer.
- `clear_acc` input 1: zero the accumulator.
- `done` input 1: frame complete; start draining.
- `res_rd` input 1: consumer pops `res_data` when `res_valid` is high.
- `res_data` output N: head-of-buffer result.
- `res_valid` output 1: `res_data` is valid (DRAIN state and buffer non-empty).
- `res_count` output clog2(Q+1): entries currently buffered.
- `overflow` output 1: sticky; a result was dropped.

## Operation
- `ACC_W` = 2N + clog2(D) + 1 bits, signed; the accumulator never wraps within D products.
- `write_x` and `write_w` are independent and may be high in the same cycle.
- Product is signed X*W, 2N bits, sign-extended to `ACC_W`.
- Accumulator update priority per cycle:
  - `clear_acc`: acc <= 0; any `acc_write` in the same cycle is ignored.
  - else `acc_write`: acc <= acc + product, using X/W values registered before this edge.
- Result = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - Clamped to [-2^(N-1), 2^(N-1)-1].
- `res_write` stores the result computed from acc as it was before the same edge.
- Buffer is a circular FIFO; write and read pointers wrap modulo Q.
- State machine:
  - COLLECT, the reset state:
    - `res_write` with count<Q pushes; count=Q drops the result and sets `overflow`.
    - `done` with count>0 moves to DRAIN.
    - `done` with count=0 stays in COLLECT with no effect.
  - DRAIN:
    - `res_valid` = 1 whenever count>0.
    - `res_rd` && `res_valid` pops (read pointer +1 mod Q, count -1).
    - The pop that empties the buffer returns to COLLECT on the same edge.
    - `res_write` in DRAIN drops the result and sets `overflow`.
    - `done` in DRAIN is ignored.
- `res_rd` while `res_valid`=0 has no effect.
- `overflow` clears only on `rst`.
- Accumulator and operand registers are unaffected by state; the controller may begin the next frame during DRAIN.

## Timing
- Reset values: `res_data` = 0 (buffer contents zeroed), `res_valid` = 0, `res_count` = 0, `overflow` = 0. Internal: acc = 0, X = W = 0, pointers = 0, state COLLECT.
- Asserting `rst` mid-frame or mid-drain discards all buffered results immediately (asynchronous).
- Operand latch: 1 cycle. `acc_write` may follow `write_x`/`write_w` on the next cycle.
- Accumulate latency: 1 cycle. `res_write` on the cycle after the last `acc_write` captures the full sum.
- `res_count` updates on the edge of the push.
- `done` sampled at edge k gives `res_valid` = 1 from edge k onward.
- `res_data` is combinational from the buffer at the read pointer; it is stable while `res_valid`=1 and `res_rd`=0.
- Back-to-back pops: one per cycle.

## Configuration
- `MAC_RELU_EN` defined: after saturation, a negative result is replaced by 0 before storing.
- `MAC_RELU_EN` undefined: signed results are stored unchanged.
- `overflow` behaviour and all timing are identical in both builds.

## Test plan
All scenarios use N=8, FRAC=4, D=4, Q=4.
- Single product: reset; x=0x10, w=0x20; one `acc_write`, one `res_write`; `done`, `res_rd`=1 -> `res_valid` rises after the `done` edge, `res_data`=0x20, then `res_count`=0 and state COLLECT.
- Saturation: four `acc_write`s of 0x10*0x20 (acc=2048), `res_write`, `done` -> `res_data`=0x7F.
- Negative and ReLU: x=0xF0, w=0x20, one `acc_write`, `res_write`, `done` -> `res_data`=0xE0; with `MAC_RELU_EN` -> 0x00.
- Clear priority and wrap:
  - `clear_acc` and `acc_write` in the same cycle -> acc stays 0.
  - Push 4 results (0x01..0x04), drain 4, push 4 more (0x05..0x08), drain with `res_rd` toggling -> output order 0x01..0x08, no gaps or duplicates.
- Overflow: 5 `res_write`s in COLLECT -> `res_count`=4, `overflow`=1, fifth dropped.
  - `res_write` during DRAIN -> count unchanged, `overflow` stays 1.
- Reset mid-drain: assert `rst` with `res_count`=3 -> `res_valid`=0, `res_count`=0, `overflow`=0 immediately; `done` with count 0 afterwards -> `res_valid` stays 0.

Source files
------------

// File: rtl/mac_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : mac_datapath
//  Purpose  : Execution datapath for the dot-product controller. Latches X/W
//             operands, multiply-accumulates them in signed fixed point,
//             scales and saturates each dot product into a Q-deep circular
//             result buffer, then drains that buffer over valid/ready once
//             the controller signals done.
//  Ports    : clk, rst (async, active-high)
//             write_x/x_in, write_w/w_in  - operand latches
//             acc_write, clear_acc        - accumulator control
//             res_write                   - store scaled/saturated result
//             done                        - frame complete, start draining
//             res_rd                      - consumer pop strobe
//             res_data/res_valid          - head-of-buffer result
//             res_count                   - entries currently buffered
//             overflow                    - sticky, a result was dropped
//  Config   : MAC_RELU_EN - clamp negative results to zero before storing
//  Revision : 1.0 - initial release
// ============================================================================
module mac_datapath #(
  parameter int N    = 8,
  parameter int D    = 4,
  parameter int Q    = 4,
  parameter int FRAC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_x,
  input  logic                   write_w,
  input  logic [N-1:0]           x_in,
  input  logic [N-1:0]           w_in,
  input  logic                   acc_write,
  input  logic                   res_write,
  input  logic                   clear_acc,
  input  logic                   done,
  input  logic                   res_rd,
  output logic [N-1:0]           res_data,
  output logic                   res_valid,
  output logic [$clog2(Q+1)-1:0] res_count,
  output logic                   overflow
);

  // Guard bits let D full-scale products accumulate without wrapping.
  localparam int ACC_W = 2*N + $clog2(D) + 1;
  localparam int CW    = $clog2(Q+1);
  localparam int PW    = (Q > 1) ? $clog2(Q) : 1;

  // Saturation bounds expressed at accumulator width for a signed compare.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic signed [N-1:0]     RES_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0]     RES_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DRAIN   = 1'b1
  } state_t;

  logic signed [N-1:0]     x_q, x_d;
  logic signed [N-1:0]     w_q, w_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N-1:0]            mem_q [Q];
  logic [N-1:0]            mem_d [Q];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  state_t                  state_q, state_d;
  logic                    overflow_q, overflow_d;

  logic signed [2*N-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shift;
  logic signed [N-1:0]     w_sat;
  logic [N-1:0]            w_res;
  logic                    w_full;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_valid;
  logic                    w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Q-1)) ? '0 : p + 1'b1;
  endfunction

  // Signed product, sign-extended into the accumulator.
  assign w_prod     = x_q * w_q;
  assign w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};

  // Arithmetic shift drops fractional bits, rounding toward -inf.
  assign w_shift = acc_q >>> FRAC;

  always_comb begin
    w_sat = w_shift[N-1:0];
    if (w_shift > SAT_MAX) begin
      w_sat = RES_MAX;
    end else if (w_shift < SAT_MIN) begin
      w_sat = RES_MIN;
    end
  end

`ifdef MAC_RELU_EN
  assign w_res = w_sat[N-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  assign w_full  = (count_q == CW'(Q));
  assign w_push  = res_write && (state_q == ST_COLLECT) && !w_full;
  // Any store that cannot be accepted (full, or arriving while draining) is lost.
  assign w_drop  = res_write && !w_push;
  assign w_valid = (state_q == ST_DRAIN) && (count_q != '0);
  assign w_pop   = w_valid && res_rd;

  always_comb begin
    x_d        = write_x ? x_in : x_q;
    w_d        = write_w ? w_in : w_q;

    acc_d      = acc_q;
    if (clear_acc) begin
      acc_d = '0;
    end else if (acc_write) begin
      acc_d = acc_q + w_prod_ext;
    end

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | w_drop;

    // Push only happens in COLLECT and pop only in DRAIN, so they never collide.
    if (w_push) begin
      mem_d[wr_ptr_q] = w_res;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      count_d         = count_q + 1'b1;
    end else if (w_pop) begin
      rd_ptr_d        = ptr_inc(rd_ptr_q);
      count_d         = count_q - 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (done && (count_q != '0)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The pop that empties the buffer hands control back on the same edge.
        if (w_pop && (count_q == CW'(1))) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      w_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < Q; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_COLLECT;
      overflow_q <= 1'b0;
    end else begin
      x_q        <= x_d;
      w_q        <= w_d;
      acc_q      <= acc_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  assign res_data  = mem_q[rd_ptr_q];
  assign res_valid = w_valid;
  assign res_count = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire
